obi_bus_arbiter: RTL
====================

Name: obi_bus_arbiter

Overview:
- Shares one OBI device port (unified memory or TCM) between two OBI hosts: host 0 is instruction fetch, host 1 is the memory-stage data driver.
- Arbitrates requests round-robin and holds the selection stable while a request waits for grant.
- Records the owner of every accepted transaction in an in-order ID FIFO, so each response (rvalid, rdata) is routed back to the host that issued it.
- Sits between the core's two OBI host drivers and the single external memory port.

Parameters:
- ADDR_W, 64, address width of all ports.
- DATA_W, 64, data width; byte-enable width is DATA_W/8.
- MAX_OUTSTANDING, 2, depth of the response ID FIFO; must be a power of 2 and at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- h0_req_i / h1_req_i  in  1  host request.
- h0_gnt_o / h1_gnt_o  out  1  host grant.
- h0_addr_i / h1_addr_i  in  ADDR_W  host address.
- h0_we_i / h1_we_i  in  1  host write enable.
- h0_be_i / h1_be_i  in  DATA_W/8  host byte enables.
- h0_wdata_i / h1_wdata_i  in  DATA_W  host write data.
- h0_rvalid_o / h1_rvalid_o  out  1  host response valid.
- h0_rdata_o / h1_rdata_o  out  DATA_W  host read data; zero when that host's rvalid is low.
- dev_req_o  out  1  device request.
- dev_gnt_i  in  1  device grant.
- dev_addr_o  out  ADDR_W  device address.
- dev_we_o  out  1  device write enable.
- dev_be_o  out  DATA_W/8  device byte enables.
- dev_wdata_o  out  DATA_W  device write data.
- dev_rvalid_i  in  1  device response valid.
- dev_rdata_i  in  DATA_W  device read data.
- outstanding_o  out  clog2(MAX_OUTSTANDING)+1  count of accepted transactions awaiting response.
- protocol_err_o  out  1  sticky flag: a response arrived with no transaction outstanding.

Behaviour:
- Reset (async, rst_i=1):
  - FIFO empty; outstanding_o=0.
  - last_grant=1, so host 0 wins the first tie.
  - lock=0; protocol_err_o=0.
  - Combinational outputs follow from reset state: dev_req_o=0, all gnt/rvalid outputs 0.
- Selection (sel):
  - If lock=1, sel = locked host.
  - Otherwise, if only one host requests, sel = that host.
  - If both request, sel = the host not equal to last_grant.
  - If neither requests, no selection.
- Request path:
  - dev_req_o = (any host req) & (outstanding_o < MAX_OUTSTANDING).
  - dev_addr/we/be/wdata mux from sel; they are zero when dev_req_o=0.
  - Zero added latency: the request passes combinationally in the same cycle.
- Grant path:
  - hN_gnt_o = dev_req_o & dev_gnt_i & (sel==N).
  - The non-selected host sees gnt=0 and must keep holding its request (OBI rule).
- Lock:
  - Set when dev_req_o & !dev_gnt_i; cleared on accept.
  - Guarantees the device sees stable address/data until grant, even if the other host raises req meanwhile.
- Accept (dev_req_o & dev_gnt_i):
  - Push sel into the FIFO.
  - last_grant <= sel.
  - outstanding increments, unless a pop happens in the same cycle.
- Response (dev_rvalid_i):
  - With FIFO non-empty: hN_rvalid_o = 1 for N = FIFO head, in the same cycle; hN_rdata_o = dev_rdata_i; pop the head.
  - With FIFO empty: no host rvalid; protocol_err_o <= 1, held until reset.
- Full FIFO: when outstanding == MAX_OUTSTANDING, dev_req_o=0, even if a pop occurs in the same cycle. This keeps the req path free of a combinational rvalid dependency.
- Simultaneous push and pop: both take effect; count unchanged; FIFO order preserved.
- Pointer wrap-around: FIFO read/write pointers wrap modulo MAX_OUTSTANDING; full/empty are derived from the count.
- Reset mid-operation: all outstanding IDs are discarded. A device response arriving after reset sets protocol_err_o; the integrator must also reset the device.
- A host dropping req while locked is a host protocol violation. The arbiter still clears lock when neither host requests.

Decomposition:
- Shared package Lucid64.vh gains:
  - OBI_ADDR_W and OBI_DATA_W constants.
  - HOST_ID_IFETCH=1'b0 and HOST_ID_DMEM=1'b1.
- One sub-module: obi_rsp_id_fifo, a parameterised-depth, 1-bit-wide in-order FIFO with count output, async active-high reset, and simultaneous push/pop support.

Test Plan:
- h0 only, dev_gnt_i=1, rvalid after 1 cycle, rdata=0xDEAD_BEEF -> h0_gnt_o=1 same cycle; h0_rvalid_o=1 with rdata 0xDEAD_BEEF; h1 outputs stay 0; outstanding_o 0->1->0.
- Both req every cycle, gnt=1, rvalid 1 cycle later -> grants alternate h0,h1,h0,h1; each rvalid is routed to the matching host in issue order.
- h1 req with dev_gnt_i=0 for 3 cycles, h0 raises req in cycle 2 -> dev_addr_o stays h1_addr_i all 3 cycles; h1 granted first; h0 granted on the next accept.
- MAX_OUTSTANDING=2, two accepts with no rvalid -> dev_req_o=0 on the third request; after one rvalid, dev_req_o returns to 1 the following cycle.
- dev_rvalid_i pulse with outstanding_o=0 -> protocol_err_o=1 and held; no host rvalid; cleared only by rst_i.
- Assert rst_i asynchronously with 2 outstanding and lock=1 -> outstanding_o=0, dev_req_o=0 immediately; after release, host 0 wins the first tie.

Source files
------------

// File: rtl/obi_bus_arbiter_pkg.sv
// Shared OBI constants and host IDs for the
// instruction-fetch / data-memory bus arbiter.
package obi_bus_arbiter_pkg;

  localparam int OBI_ADDR_W = 64;
  localparam int OBI_DATA_W = 64;

  localparam logic HOST_ID_IFETCH = 1'b0;
  localparam logic HOST_ID_DMEM   = 1'b1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/obi_rsp_id_fifo.sv
// In-order 1-bit host-ID FIFO with occupancy count.
// Push and pop may coincide; the caller never overflows/underflows it.
module obi_rsp_id_fifo
  import obi_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  data_i,
  input  logic                  pop_i,
  output logic                  data_o,
  output logic [cnt_w(DEPTH)-1:0] count_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;

  assign data_o  = mem[rptr];
  assign count_o = cnt;

  // storage, wrapping pointers and count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_i) begin
        mem[wptr] <= data_i;
        wptr      <= (wptr == LAST) ? '0 : wptr + PW'(1);
      end
      if (pop_i) begin
        rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
      end
      cnt <= cnt + CW'(push_i) - CW'(pop_i);
    end
  end

endmodule

// File: rtl/obi_bus_arbiter.sv
// Round-robin arbiter sharing one OBI device port between
// ifetch (host 0) and dmem (host 1), with in-order response routing.
module obi_bus_arbiter
  import obi_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W          = OBI_ADDR_W,
  parameter int DATA_W          = OBI_DATA_W,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  h0_req_i,
  output logic                  h0_gnt_o,
  input  logic [ADDR_W-1:0]     h0_addr_i,
  input  logic                  h0_we_i,
  input  logic [DATA_W/8-1:0]   h0_be_i,
  input  logic [DATA_W-1:0]     h0_wdata_i,
  output logic                  h0_rvalid_o,
  output logic [DATA_W-1:0]     h0_rdata_o,
  input  logic                  h1_req_i,
  output logic                  h1_gnt_o,
  input  logic [ADDR_W-1:0]     h1_addr_i,
  input  logic                  h1_we_i,
  input  logic [DATA_W/8-1:0]   h1_be_i,
  input  logic [DATA_W-1:0]     h1_wdata_i,
  output logic                  h1_rvalid_o,
  output logic [DATA_W-1:0]     h1_rdata_o,
  output logic                  dev_req_o,
  input  logic                  dev_gnt_i,
  output logic [ADDR_W-1:0]     dev_addr_o,
  output logic                  dev_we_o,
  output logic [DATA_W/8-1:0]   dev_be_o,
  output logic [DATA_W-1:0]     dev_wdata_o,
  input  logic                  dev_rvalid_i,
  input  logic [DATA_W-1:0]     dev_rdata_i,
  output logic [cnt_w(MAX_OUTSTANDING)-1:0] outstanding_o,
  output logic                  protocol_err_o
);

  localparam int CW = cnt_w(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic any_req;
  logic sel;
  logic lock_q;
  logic lock_id_q;
  logic last_q;
  logic accept;
  logic pop;
  logic head;
  logic empty;
  logic full;
  logic [CW-1:0] cnt;

  assign any_req = h0_req_i | h1_req_i;
  assign full    = (cnt == MAX_CNT);
  assign empty   = (cnt == '0);

  // pick the host driving the device port this cycle
  always_comb begin
    sel = HOST_ID_IFETCH;
    unique case (1'b1)
      lock_q:                          sel = lock_id_q;
      !lock_q && h0_req_i && !h1_req_i: sel = HOST_ID_IFETCH;
      !lock_q && h1_req_i && !h0_req_i: sel = HOST_ID_DMEM;
      !lock_q && h0_req_i && h1_req_i:  sel = ~last_q;
      default: ;
    endcase
  end

  assign dev_req_o = any_req & ~full & ~rst_i;
  assign accept    = dev_req_o & dev_gnt_i;
  assign h0_gnt_o  = accept & (sel == HOST_ID_IFETCH);
  assign h1_gnt_o  = accept & (sel == HOST_ID_DMEM);

  assign dev_addr_o  = !dev_req_o ? '0 : sel ? h1_addr_i  : h0_addr_i;
  assign dev_we_o    = !dev_req_o ? '0 : sel ? h1_we_i    : h0_we_i;
  assign dev_be_o    = !dev_req_o ? '0 : sel ? h1_be_i    : h0_be_i;
  assign dev_wdata_o = !dev_req_o ? '0 : sel ? h1_wdata_i : h0_wdata_i;

  assign pop         = dev_rvalid_i & ~empty;
  assign h0_rvalid_o = pop & (head == HOST_ID_IFETCH);
  assign h1_rvalid_o = pop & (head == HOST_ID_DMEM);
  assign h0_rdata_o  = h0_rvalid_o ? dev_rdata_i : '0;
  assign h1_rdata_o  = h1_rvalid_o ? dev_rdata_i : '0;

  assign outstanding_o = cnt;

  // round-robin history and hold-until-grant lock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q    <= HOST_ID_DMEM;
      lock_q    <= 1'b0;
      lock_id_q <= HOST_ID_IFETCH;
    end else begin
      if (accept) begin
        last_q <= sel;
        lock_q <= 1'b0;
      end else if (dev_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end else if (!any_req) begin
        lock_q <= 1'b0;
      end
    end
  end

  // sticky flag for responses with nothing outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      protocol_err_o <= 1'b0;
    end else if (dev_rvalid_i && empty) begin
      protocol_err_o <= 1'b1;
    end
  end

  obi_rsp_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (cnt)
  );

endmodule
